// File: rtl/gray_rx_monitor.sv
// rtl/gray_rx_monitor.sv - gray bus synchronizer, decoder and modulo step tracker
module gray_rx_monitor #(
   parameter int WIDTH       = 4,
   parameter int MOD         = 11,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             valid,
   output logic             step,
   output logic             err,
   output logic [CNT_W-1:0] steps_cnt
);

   // One extra bit so MOD == 2^WIDTH is representable in range checks.
   localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
   localparam logic [WIDTH-1:0] LAST  = WIDTH'(MOD - 1);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] bin_d;
   logic [WIDTH-1:0] bin_q;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             valid_q, valid_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             out_of_range;
   logic             is_succ;

   // Flop chain that brings the foreign gray bus into the local clock.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Gray to binary: each binary bit is the parity of the gray bits at and above it.
   always_comb begin
      bin_d = '0;
      for (int i = 0; i < WIDTH; i++) bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
   end

   // Registered decode; this is the value the tracker judges.
   always_ff @(posedge clk) begin
      if (!rst) bin_q <= '0;
      else      bin_q <= bin_d;
   end

   assign out_of_range = {1'b0, bin_q} >= MOD_W;
   assign is_succ      = (prev_q == LAST) ? (bin_q == '0)
                                          : ({1'b0, bin_q} == ({1'b0, prev_q} + (WIDTH+1)'(1)));

   // Tracker register bank.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= INIT;
         prev_q  <= '0;
         valid_q <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         valid_q <= valid_d;
         step_q  <= step_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Tracker next-state: lock in INIT, judge each new code in TRACK, hold in FAULT until cleared.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      valid_d = valid_q;
      step_d  = 1'b0;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            if (en) begin
               prev_d  = bin_q;
               valid_d = 1'b1;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (!en) begin
               // Follow silently so resuming never looks like a jump.
               prev_d = bin_q;
            end else if (out_of_range) begin
               err_d   = 1'b1;
               valid_d = 1'b0;
               state_d = FAULT;
            end else if (bin_q != prev_q) begin
               if (is_succ) begin
                  step_d = 1'b1;
                  cnt_d  = cnt_q + CNT_W'(1);
                  prev_d = bin_q;
               end else begin
                  err_d   = 1'b1;
                  valid_d = 1'b0;
                  state_d = FAULT;
               end
            end
         end
         FAULT: begin
            if (err_clr) begin
               err_d   = 1'b0;
               state_d = INIT;
            end
         end
         default: begin
            state_d = INIT;
            valid_d = 1'b0;
         end
      endcase
   end

   assign bin_out   = bin_q;
   assign valid     = valid_q;
   assign step      = step_q;
   assign err       = err_q;
   assign steps_cnt = cnt_q;

endmodule
